seq_detector_prog: RTL and testbench

//   Runtime-programmable serial bit-pattern detector with a parametrised pattern length.

---
 rtl/seq_detector_prog.sv | 115 +++++++++++
 tb/tb_seq_detector_prog.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: valid-qualified bit stream,
// overlapping or non-overlapping matching, saturating match counter.
module seq_detector_prog #(
    parameter int SEQ_LEN = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [SEQ_LEN-1:0] pattern,
    input  logic               overlap_en,
    input  logic               in_valid,
    input  logic               In,
    input  logic               cnt_clr,
    output logic               Out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat,
    output logic               armed
);

    localparam int                FILL_W    = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_UNARMED,
        ST_FILLING,
        ST_DETECT
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [SEQ_LEN-1:0] r_pat,    w_pat_nxt;
    logic [SEQ_LEN-1:0] r_hist,   w_hist_nxt;
    logic [FILL_W-1:0]  r_fill,   w_fill_nxt;
    logic [SEQ_LEN-1:0] w_hist_shift;
    logic [FILL_W-1:0]  w_fill_inc;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_sample;
    logic               w_match;
    logic               r_out;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;

    // A load on the same edge as a valid bit wins and the bit is dropped.
    assign w_sample     = in_valid && !load && (r_state != ST_UNARMED);
    assign w_hist_shift = {r_hist[SEQ_LEN-2:0], In};
    assign w_fill_inc   = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
    assign w_match      = w_sample && (w_hist_shift == r_pat) && (w_fill_inc == FILL_FULL);
    assign w_cnt_inc    = r_cnt + CNT_W'(1);

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        if (load) begin
            w_pat_nxt   = pattern;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_state_nxt = ST_FILLING;
        end else if (w_sample) begin
            if (w_match && !overlap_en) begin
                w_hist_nxt  = '0;
                w_fill_nxt  = '0;
                w_state_nxt = ST_FILLING;
            end else begin
                w_hist_nxt  = w_hist_shift;
                w_fill_nxt  = w_fill_inc;
                w_state_nxt = (w_fill_inc == FILL_FULL) ? ST_DETECT : ST_FILLING;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_UNARMED;
            r_pat   <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    // Clear beats a same-edge increment; the match pulse itself is unaffected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= 1'b0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_out <= w_match;
            if (cnt_clr) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_match && (r_cnt != CNT_MAX)) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == CNT_MAX) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign Out       = r_out;
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;
    assign armed     = (r_state != ST_UNARMED);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Table-driven bench for seq_detector_prog: 8-bit counter instance for the
// detection cases, 2-bit counter instance for saturation, clear and reset.
module tb_seq_detector_prog;

    typedef struct {
        logic       ld;
        logic [4:0] pat;
        logic       ov;
        logic       v;
        logic       d;
        logic       clr;
        logic       e_out;
        int         e_cnt;
        logic       e_sat;
        logic       e_arm;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [4:0] pattern = '0;
    logic       overlap_en = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       out_a, sat_a, arm_a;
    logic [7:0] cnt_a;
    logic       out_b, sat_b, arm_b;
    logic [1:0] cnt_b;

    int   total = 0;
    int   bad = 0;
    bit   use_small = 1'b0;
    vec_t tbl[$];
    vec_t sb[$];

    seq_detector_prog #(.SEQ_LEN(5), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .load(load), .pattern(pattern),
        .overlap_en(overlap_en), .in_valid(in_valid), .In(in_bit), .cnt_clr(cnt_clr),
        .Out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .armed(arm_a)
    );

    seq_detector_prog #(.SEQ_LEN(5), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .load(load), .pattern(pattern),
        .overlap_en(overlap_en), .in_valid(in_valid), .In(in_bit), .cnt_clr(cnt_clr),
        .Out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .armed(arm_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic ld, input logic [4:0] pat, input logic ov,
                                input logic v, input logic d, input logic clr,
                                input logic e_out, input int e_cnt, input logic e_sat,
                                input logic e_arm);
        vec_t t;
        t.ld = ld; t.pat = pat; t.ov = ov; t.v = v; t.d = d; t.clr = clr;
        t.e_out = e_out; t.e_cnt = e_cnt; t.e_sat = e_sat; t.e_arm = e_arm;
        tbl.push_back(t);
    endfunction

    task automatic check_outputs(input string tag, input logic e_out, input int e_cnt,
                                 input logic e_sat, input logic e_arm);
        if (use_small) begin
            check({tag, ".out"}, int'(out_b), int'(e_out));
            check({tag, ".cnt"}, int'(cnt_b), e_cnt);
            check({tag, ".sat"}, int'(sat_b), int'(e_sat));
            check({tag, ".armed"}, int'(arm_b), int'(e_arm));
        end else begin
            check({tag, ".out"}, int'(out_a), int'(e_out));
            check({tag, ".cnt"}, int'(cnt_a), e_cnt);
            check({tag, ".sat"}, int'(sat_a), int'(e_sat));
            check({tag, ".armed"}, int'(arm_a), int'(e_arm));
        end
    endtask

    // Inputs change on the falling edge; results are checked on the next falling edge.
    task automatic run_table(input string phase);
        vec_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            load = tbl[i].ld; pattern = tbl[i].pat; overlap_en = tbl[i].ov;
            in_valid = tbl[i].v; in_bit = tbl[i].d; cnt_clr = tbl[i].clr;
            sb.push_back(tbl[i]);
            @(negedge clk);
            if (sb.size() == 0) begin
                check($sformatf("%s[%0d].scoreboard_empty", phase, i), 0, 1);
            end else begin
                e = sb.pop_front();
                check_outputs($sformatf("%s[%0d]", phase, i), e.e_out, e.e_cnt, e.e_sat, e.e_arm);
            end
        end
        tbl.delete();
        load = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        logic [4:0] p;
        logic [7:0] ov_stream;
        logic [4:0] mm_stream;
        logic [4:0] alt_stream;
        p          = 5'b11011;
        ov_stream  = 8'b11011011;
        mm_stream  = 5'b11001;
        alt_stream = 5'b10101;

        repeat (2) @(negedge clk);
        use_small = 1'b0;
        check_outputs("reset", 1'b0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Unarmed: pattern bits are ignored.
        for (int i = 4; i >= 0; i--) add(0, p, 1, 1, p[i], 0, 0, 0, 0, 0);
        // Overlapping detection: matches after bits 5 and 8.
        add(1, p, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            add(0, p, 1, 1, ov_stream[7-i], 0, (i == 4 || i == 7), (i < 4) ? 0 : (i < 7) ? 1 : 2, 0, 1);
        add(0, p, 1, 0, 0, 0, 0, 2, 0, 1);
        // Non-overlapping detection: only the first match.
        add(1, p, 0, 0, 0, 0, 0, 2, 0, 1);
        for (int i = 0; i < 8; i++)
            add(0, p, 0, 1, ov_stream[7-i], 0, (i == 4), (i < 4) ? 2 : 3, 0, 1);
        // Gapped stream: three idle cycles (with In=1) between valid bits.
        add(1, p, 0, 0, 0, 0, 0, 3, 0, 1);
        for (int i = 4; i >= 0; i--) begin
            add(0, p, 0, 1, p[i], 0, (i == 0), (i == 0) ? 4 : 3, 0, 1);
            if (i != 0) for (int g = 0; g < 3; g++) add(0, p, 0, 0, 1, 0, 0, 3, 0, 1);
        end
        // Mismatching stream, then reload with a same-edge bit that must be dropped.
        for (int i = 4; i >= 0; i--) add(0, p, 0, 1, mm_stream[i], 0, 0, 4, 0, 1);
        add(1, 5'b10101, 0, 1, 1, 0, 0, 4, 0, 1);
        for (int i = 4; i >= 0; i--)
            add(0, 5'b10101, 0, 1, alt_stream[i], 0, (i == 0), (i == 0) ? 5 : 4, 0, 1);
        add(1, 5'b10101, 0, 1, 1, 0, 0, 5, 0, 1);
        for (int i = 3; i >= 0; i--) add(0, 5'b10101, 0, 1, alt_stream[i+1], 0, 0, 5, 0, 1);
        add(0, 5'b10101, 0, 0, 0, 1, 0, 0, 0, 1);
        run_table("main");

        // Saturation on the 2-bit counter instance.
        reset = 1'b0;
        #1;
        check_outputs("reset2_a", 1'b0, 0, 1'b0, 1'b0);
        use_small = 1'b1;
        check_outputs("reset2_b", 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        add(1, 5'b11111, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++)
            add(0, 5'b11111, 1, 1, 1, 0, (i >= 4), (i < 4) ? 0 : i - 3, (i == 6), 1);
        add(0, 5'b11111, 1, 1, 1, 1, 1, 0, 0, 1);
        add(0, 5'b11111, 1, 1, 1, 0, 1, 1, 0, 1);
        add(0, 5'b11111, 1, 1, 1, 0, 1, 2, 0, 1);
        add(0, 5'b11111, 1, 1, 1, 0, 1, 3, 1, 1);
        add(0, 5'b11111, 1, 1, 1, 0, 1, 3, 1, 1);
        run_table("sat");

        // Asynchronous reset in the middle of a stream with Out high beforehand.
        in_valid = 1'b1; in_bit = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_outputs("midreset", 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) add(0, 5'b11111, 1, 1, 1, 0, 0, 0, 0, 0);
        run_table("postreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
